dreg_univ: RTL and testbench

- Parametrised successor to the 4-bit D-storage element: a WIDTH-bit clocked universal register.
- Supports load, clear, and multi-cycle shift/rotate commands under a valid/ready handshake.
- Performs one bit-step per clock and pulses done when a command completes.
- Serves as a general storage/serialiser element for later datapath blocks.

---
 rtl/dreg_pkg.sv | 28 ++
 rtl/dreg_step.sv | 52 +++++
 rtl/dreg_univ.sv | 157 +++++++++++++++
 tb/tb_dreg_univ.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dreg_pkg.sv
// rtl/dreg_pkg.sv - shared opcodes, state encoding and shift-amount helper for dreg_univ
// Contents:
//   OP_NOP..OP_ASR : 3-bit command opcodes
//   state_e        : controller state (ST_IDLE=0, ST_SHIFT=1)
//   sat_amt()      : clamps a requested shift amount to the register width
package dreg_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_CLEAR = 3'd2;
  localparam logic [2:0] OP_SHL   = 3'd3;
  localparam logic [2:0] OP_SHR   = 3'd4;
  localparam logic [2:0] OP_ROL   = 3'd5;
  localparam logic [2:0] OP_ROR   = 3'd6;
  localparam logic [2:0] OP_ASR   = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Shifting further than the register width only ever repeats fill bits,
  // so anything larger is clamped to WIDTH steps.
  function automatic int unsigned sat_amt(input int unsigned amt, input int unsigned width);
    return (amt > width) ? width : amt;
  endfunction

endpackage

// File: rtl/dreg_step.sv
// rtl/dreg_step.sv - combinational single-bit step for shift/rotate opcodes
// Ports:
//   op      in  3      opcode of the running shift/rotate command
//   q       in  WIDTH  current register contents
//   si      in  1      serial input (used by SHL/SHR only)
//   next_q  out WIDTH  register contents after one step
//   next_so out 1      bit leaving the register on this step
module dreg_step
  import dreg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] q,
  input  logic             si,
  output logic [WIDTH-1:0] next_q,
  output logic             next_so
);

  always_comb begin
    next_q  = q;
    next_so = 1'b0;
    case (op)
      OP_SHL: begin
        next_q  = {q[WIDTH-2:0], si};
        next_so = q[WIDTH-1];
      end
      OP_SHR: begin
        next_q  = {si, q[WIDTH-1:1]};
        next_so = q[0];
      end
      OP_ROL: begin
        next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
        next_so = q[WIDTH-1];
      end
      OP_ROR: begin
        next_q  = {q[0], q[WIDTH-1:1]};
        next_so = q[0];
      end
      OP_ASR: begin
        // Sign bit is replicated; si plays no part.
        next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
        next_so = q[0];
      end
      default: begin
        next_q  = q;
        next_so = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dreg_univ.sv
// rtl/dreg_univ.sv - WIDTH-bit universal register with load/clear/shift/rotate commands
// Optional build macro: DREG_PARITY_EN adds the registered parity output q_par.
// Ports:
//   clk       in  1      rising-edge clock
//   rst_n     in  1      asynchronous active-low reset
//   cmd_valid in  1      command offered
//   cmd_ready out 1      command accepted this cycle if cmd_valid (high in IDLE)
//   cmd_op    in  3      opcode (NOP, LOAD, CLEAR, SHL, SHR, ROL, ROR, ASR)
//   cmd_amt   in  CNT_W  bit-steps for shift/rotate, saturated to WIDTH
//   d         in  WIDTH  parallel load data
//   si        in  1      serial input, sampled on each SHL/SHR step edge
//   q         out WIDTH  register contents
//   so        out 1      bit shifted/rotated out on the latest step
//   busy      out 1      shift/rotate in progress
//   done      out 1      one-cycle completion pulse per accepted command
//   q_par     out 1      registered XOR-reduce of q (DREG_PARITY_EN only)
module dreg_univ
  import dreg_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] d,
  input  logic             si,
  output logic [WIDTH-1:0] q,
  output logic             so,
  output logic             busy,
  output logic             done
`ifdef DREG_PARITY_EN
  ,
  output logic             q_par
`endif
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             so_q, so_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] amt_sat;
  logic [WIDTH-1:0] step_q;
  logic             step_so;

  assign amt_sat = CNT_W'(sat_amt(32'(cmd_amt), WIDTH));

  dreg_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op      (op_q),
    .q       (q_q),
    .si      (si),
    .next_q  (step_q),
    .next_so (step_so)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    so_d    = so_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_NOP: begin
              done_d = 1'b1;
            end
            OP_LOAD: begin
              q_d    = d;
              done_d = 1'b1;
            end
            OP_CLEAR: begin
              q_d    = '0;
              done_d = 1'b1;
            end
            default: begin
              // Opcode is latched so mid-shift changes on cmd_op are harmless.
              op_d = cmd_op;
              if (amt_sat == '0) begin
                done_d = 1'b1;
              end else begin
                cnt_d   = amt_sat;
                state_d = ST_SHIFT;
              end
            end
          endcase
        end
      end

      ST_SHIFT: begin
        q_d   = step_q;
        so_d  = step_so;
        cnt_d = cnt_q - CNT_W'(1);
        // The final step edge also raises done, so done never overlaps busy.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      q_q     <= '0;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      so_q    <= so_d;
      done_q  <= done_d;
    end
  end

  assign q         = q_q;
  assign so        = so_q;
  assign done      = done_q;
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_SHIFT);

`ifdef DREG_PARITY_EN
  logic par_q;

  // Computed from the next-state value so it lands on the same edge as q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^q_d;
    end
  end

  assign q_par = par_q;
`endif

endmodule

// File: tb/tb_dreg_univ.sv
// tb/tb_dreg_univ.sv - directed self-checking bench for dreg_univ (WIDTH=4)
module tb_dreg_univ;
  import dreg_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [2:0] cmd_amt = 3'd0;
  logic [3:0] d = 4'd0;
  logic       si = 1'b0;
  logic       cmd_ready;
  logic [3:0] q;
  logic       so;
  logic       busy;
  logic       done;
`ifdef DREG_PARITY_EN
  logic       q_par;
`endif

  int checks = 0;
  int failures = 0;

  dreg_univ #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .d         (d),
    .si        (si),
    .q         (q),
    .so        (so),
    .busy      (busy),
    .done      (done)
`ifdef DREG_PARITY_EN
    ,
    .q_par     (q_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command, then samples once per cycle until done (bounded).
  // lat = number of edges from the accept edge to the edge that raised done.
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] amt, input logic [3:0] dv,
                         output int busy_cycles, output int lat);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = amt;
    d         = dv;
    tick();
    cmd_valid = 1'b0;
    busy_cycles = 0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (busy) busy_cycles++;
      if (done) begin
        lat = i;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_op = OP_LOAD; d = 4'hF; si = 1'b1;
    tick(); tick();
    checks++; if (q !== 4'b0000) begin failures++; $display("FAIL reset_q got=%b exp=0000", q); end
    checks++; if (so !== 1'b0) begin failures++; $display("FAIL reset_so got=%b exp=0", so); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef DREG_PARITY_EN
    checks++; if (q_par !== 1'b0) begin failures++; $display("FAIL reset_par got=%b exp=0", q_par); end
`endif
    cmd_valid = 1'b0; si = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_shl();
    int bc, lat;
    run_cmd(OP_LOAD, 3'd0, 4'b0110, bc, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL load_latency got=%0d exp=1", lat); end
    checks++; if (q !== 4'b0110) begin failures++; $display("FAIL load_q got=%b exp=0110", q); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL load_done_pulse got=%b exp=0", done); end
    si = 1'b1;
    run_cmd(OP_SHL, 3'd2, 4'b0000, bc, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL shl_latency got=%0d exp=3", lat); end
    checks++; if (bc !== 2) begin failures++; $display("FAIL shl_busy_cycles got=%0d exp=2", bc); end
    checks++; if (q !== 4'b1011) begin failures++; $display("FAIL shl_q got=%b exp=1011", q); end
    checks++; if (so !== 1'b1) begin failures++; $display("FAIL shl_so got=%b exp=1", so); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL shl_busy_at_done got=%b exp=0", busy); end
    si = 1'b0;
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL shl_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_rotate_asr();
    int bc, lat;
    run_cmd(OP_LOAD, 3'd0, 4'b1001, bc, lat);
    tick();
    run_cmd(OP_ROR, 3'd1, 4'b0000, bc, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL ror_latency got=%0d exp=2", lat); end
    checks++; if (q !== 4'b1100) begin failures++; $display("FAIL ror_q got=%b exp=1100", q); end
    checks++; if (so !== 1'b1) begin failures++; $display("FAIL ror_so got=%b exp=1", so); end
    tick();
    si = 1'b0;
    run_cmd(OP_ASR, 3'd2, 4'b0000, bc, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL asr_latency got=%0d exp=3", lat); end
    checks++; if (q !== 4'b1111) begin failures++; $display("FAIL asr_q got=%b exp=1111", q); end
    checks++; if (so !== 1'b0) begin failures++; $display("FAIL asr_so got=%b exp=0", so); end
    tick();
  endtask

  task automatic test_saturation_zero();
    int bc, lat;
    si = 1'b0;
    run_cmd(OP_SHR, 3'd7, 4'b0000, bc, lat);
    checks++; if (lat !== 5) begin failures++; $display("FAIL shr_sat_latency got=%0d exp=5", lat); end
    checks++; if (bc !== 4) begin failures++; $display("FAIL shr_sat_busy got=%0d exp=4", bc); end
    checks++; if (q !== 4'b0000) begin failures++; $display("FAIL shr_sat_q got=%b exp=0000", q); end
    checks++; if (so !== 1'b1) begin failures++; $display("FAIL shr_sat_so got=%b exp=1", so); end
    tick();
    run_cmd(OP_SHL, 3'd0, 4'b0000, bc, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL zero_amt_latency got=%0d exp=1", lat); end
    checks++; if (bc !== 0) begin failures++; $display("FAIL zero_amt_busy got=%0d exp=0", bc); end
    checks++; if (q !== 4'b0000) begin failures++; $display("FAIL zero_amt_q got=%b exp=0000", q); end
    checks++; if (so !== 1'b1) begin failures++; $display("FAIL zero_amt_so got=%b exp=1", so); end
    tick();
  endtask

  task automatic test_back_to_back();
    int bc, lat;
    run_cmd(OP_LOAD, 3'd0, 4'b0001, bc, lat);
    tick();
    cmd_valid = 1'b1; cmd_op = OP_ROL; cmd_amt = 3'd3;
    tick();
    // Offer a LOAD while busy: must be ignored.
    cmd_op = OP_LOAD; cmd_amt = 3'd0; d = 4'b1010;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_busy got=%b exp=0", cmd_ready); end
    tick();
    checks++; if (q !== 4'b0010) begin failures++; $display("FAIL b2b_step1_q got=%b exp=0010", q); end
    tick();
    checks++; if (q !== 4'b0100) begin failures++; $display("FAIL b2b_step2_q got=%b exp=0100", q); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    tick();
    checks++; if (q !== 4'b1000) begin failures++; $display("FAIL b2b_rol_q got=%b exp=1000", q); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_rol_done got=%b exp=1", done); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_done got=%b exp=1", cmd_ready); end
    d = 4'b0011;
    tick();
    cmd_valid = 1'b0;
    checks++; if (q !== 4'b0011) begin failures++; $display("FAIL b2b_load_q got=%b exp=0011", q); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_load_done got=%b exp=1", done); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_clear got=%b exp=0", done); end
  endtask

  task automatic test_reset_mid_op();
    int bc, lat;
    int seen_done;
    run_cmd(OP_LOAD, 3'd0, 4'b0110, bc, lat);
    tick();
    cmd_valid = 1'b1; cmd_op = OP_ROL; cmd_amt = 3'd4;
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++; if (q !== 4'b1100) begin failures++; $display("FAIL mid_step1_q got=%b exp=1100", q); end
    tick();
    checks++; if (q !== 4'b1001) begin failures++; $display("FAIL mid_step2_q got=%b exp=1001", q); end
    rst_n = 1'b0;
    #1;
    checks++; if (q !== 4'b0000) begin failures++; $display("FAIL mid_reset_q got=%b exp=0000", q); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    seen_done = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) seen_done++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) seen_done++;
    end
    checks++; if (seen_done !== 0) begin failures++; $display("FAIL mid_reset_no_done got=%0d exp=0", seen_done); end
    checks++; if (q !== 4'b0000) begin failures++; $display("FAIL mid_reset_q_after got=%b exp=0000", q); end
  endtask

`ifdef DREG_PARITY_EN
  task automatic test_parity();
    int bc, lat;
    run_cmd(OP_LOAD, 3'd0, 4'b0111, bc, lat);
    checks++; if (q_par !== 1'b1) begin failures++; $display("FAIL par_load got=%b exp=1", q_par); end
    tick();
    run_cmd(OP_CLEAR, 3'd0, 4'b0000, bc, lat);
    checks++; if (q_par !== 1'b0) begin failures++; $display("FAIL par_clear got=%b exp=0", q_par); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_load_shl();
    test_rotate_asr();
    test_saturation_zero();
    test_back_to_back();
    test_reset_mid_op();
`ifdef DREG_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
